// File: rtl/demux1to8_collect.sv
// demux1to8_collect: 1-to-N demultiplexer that collects lane writes into frames
// Ports: clk/rst (sync, active-high); din/din_valid write data and strobe;
// sel/auto_en choose target lane (sel or internal ptr); clear aborts the frame;
// lane_out live lanes; frame_out/frame_valid last completed frame and its pulse;
// wr_mask lanes written this frame; ptr auto-mode pointer; busy frame partly filled.
// Optional DEMUX_COLLECT_PARITY_EN adds parity_in (checked at completion) and parity_out.
module demux1to8_collect #(
  parameter int DATA_W = 1,
  parameter int N_CH = 8,
  parameter int SEL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_valid,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   auto_en,
  input  logic                   clear,
`ifdef DEMUX_COLLECT_PARITY_EN
  input  logic                   parity_in,
  output logic                   parity_out,
`endif
  output logic [N_CH*DATA_W-1:0] lane_out,
  output logic [N_CH*DATA_W-1:0] frame_out,
  output logic                   frame_valid,
  output logic [N_CH-1:0]        wr_mask,
  output logic [SEL_W-1:0]       ptr,
  output logic                   busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [N_CH*DATA_W-1:0] lane_q, lane_d, frame_q, frame_d, lanes_n;
  logic [N_CH-1:0] wr_mask_q, wr_mask_d, mask_n;
  logic [SEL_W-1:0] ptr_q, ptr_d, t;
  logic wr_ok, cmpl, ok;
`ifdef DEMUX_COLLECT_PARITY_EN
  logic parity_q, parity_d, par;
`endif
  always_comb begin
    t = auto_en ? ptr_q : sel;
    // clear outranks din_valid; out-of-range targets are dropped entirely
    wr_ok = din_valid && !clear && (int'(t) < N_CH);
    mask_n = wr_mask_q | (wr_ok ? (N_CH'(1) << t) : '0);
    cmpl = wr_ok && &mask_n;
    for (int k = 0; k < N_CH; k++)
      lanes_n[k*DATA_W +: DATA_W] = (wr_ok && t == SEL_W'(k)) ? din : lane_q[k*DATA_W +: DATA_W];
`ifdef DEMUX_COLLECT_PARITY_EN
    par = ^lanes_n;
    // a parity mismatch still ends the frame but publishes nothing
    ok = cmpl && (parity_in == par);
    parity_d = ok ? par : parity_q;
`else
    ok = cmpl;
`endif
    wr_mask_d = (clear || cmpl) ? '0 : mask_n;
    ptr_d = (clear || cmpl) ? '0 :
            (wr_ok && auto_en) ? (ptr_q == SEL_W'(N_CH - 1) ? '0 : ptr_q + 1'b1) : ptr_q;
    lane_d = clear ? '0 : lanes_n;
    frame_d = ok ? lanes_n : frame_q;
    state_d = clear ? IDLE :
              ok ? DONE :
              wr_ok ? (cmpl ? IDLE : FILL) :
              (state_q == DONE ? IDLE : state_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q <= '0;
      frame_q <= '0;
      wr_mask_q <= '0;
      ptr_q <= '0;
`ifdef DEMUX_COLLECT_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      frame_q <= frame_d;
      wr_mask_q <= wr_mask_d;
      ptr_q <= ptr_d;
`ifdef DEMUX_COLLECT_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end
`ifdef DEMUX_COLLECT_PARITY_EN
  assign parity_out = parity_q;
`endif
  assign lane_out = lane_q;
  assign frame_out = frame_q;
  assign frame_valid = state_q == DONE;
  assign wr_mask = wr_mask_q;
  assign ptr = ptr_q;
  assign busy = state_q == FILL;
endmodule

// File: tb/tb_demux1to8_collect.sv
// tb_demux1to8_collect: scoreboard bench for demux1to8_collect
module tb_demux1to8_collect;
  logic clk = 0, rst = 1, din = 0, din_valid = 0, auto_en = 0, clear = 0;
  logic [2:0] sel = 0;
  logic [7:0] lane_out, frame_out, wr_mask;
  logic frame_valid, busy;
  logic [2:0] ptr;
`ifdef DEMUX_COLLECT_PARITY_EN
  logic parity_in = 0, parity_out;
`endif
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  demux1to8_collect dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sel(sel),
    .auto_en(auto_en), .clear(clear),
`ifdef DEMUX_COLLECT_PARITY_EN
    .parity_in(parity_in), .parity_out(parity_out),
`endif
    .lane_out(lane_out), .frame_out(frame_out), .frame_valid(frame_valid),
    .wr_mask(wr_mask), .ptr(ptr), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && frame_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected frame_valid", 1, 0);
      else chk("frame_out", frame_out, exp_q.pop_front());
    end
  task automatic step(input logic v, input logic a, input logic [2:0] s, input logic d, input logic c);
    din_valid = v; auto_en = a; sel = s; din = d; clear = c;
    @(posedge clk); #1;
    din_valid = 0; clear = 0;
  endtask
  initial begin
    logic [7:0] p1, p3, p4;
    logic [2:0] order[8];
    p1 = 8'b01001101;
    p3 = 8'h55;
    p4 = 8'h96;
    order = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst lane_out", lane_out, 0);
    chk("rst frame_out", frame_out, 0);
    chk("rst frame_valid", frame_valid, 0);
    chk("rst wr_mask", wr_mask, 0);
    chk("rst ptr", ptr, 0);
    chk("rst busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(p1);
      step(1, 1, 0, p1[i], 0);
      if (i == 2) begin
        chk("auto ptr mid", ptr, 3);
        chk("auto mask mid", wr_mask, 8'h07);
        chk("auto busy mid", busy, 1);
      end
    end
    chk("auto fv", frame_valid, 1);
    chk("auto ptr end", ptr, 0);
    chk("auto mask end", wr_mask, 0);
    step(0, 0, 0, 0, 0);
    chk("auto fv gone", frame_valid, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(8'hFF);
      step(1, 0, order[i], 1, 0);
      if (i == 6) chk("manual no early fv", frame_valid, 0);
    end
    chk("manual ptr", ptr, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, order[i], 1, 0);
    chk("manual mask 4", wr_mask, 8'hA9);
    step(1, 0, 3, 0, 0);
    chk("rewrite mask", wr_mask, 8'hA9);
    chk("rewrite lane", lane_out, 8'hF7);
    step(1, 0, 3, 1, 0);
    for (int i = 4; i < 8; i++) begin
      if (i == 7) exp_q.push_back(8'hFF);
      step(1, 0, order[i], 1, 0);
    end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7 || i == 15) exp_q.push_back(p3);
      step(1, 1, 0, p3[i%8], 0);
      if (i == 0 || i == 8) chk("b2b busy", busy, 1);
      if (i == 7 || i == 15) begin
        chk("b2b fv", frame_valid, 1);
        chk("b2b busy done", busy, 0);
      end
    end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
    chk("pre-clear ptr", ptr, 4);
    step(1, 1, 0, 1, 1);
    chk("clear mask", wr_mask, 0);
    chk("clear ptr", ptr, 0);
    chk("clear lane", lane_out, 0);
    chk("clear frame_out", frame_out, 8'h55);
    chk("clear fv", frame_valid, 0);
    chk("clear busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(p4);
      step(1, 1, 0, p4[i], 0);
    end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
    chk("pre-rst mask", wr_mask, 8'h0F);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("mid rst lane", lane_out, 0);
    chk("mid rst frame", frame_out, 0);
    chk("mid rst mask", wr_mask, 0);
    chk("mid rst ptr", ptr, 0);
    chk("mid rst busy", busy, 0);
`ifdef DEMUX_COLLECT_PARITY_EN
    chk("mid rst parity", parity_out, 0);
    parity_in = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 0, i == 0, 0);
    chk("bad parity fv", frame_valid, 0);
    chk("bad parity frame", frame_out, 0);
    parity_in = 1;
    exp_q.push_back(8'h01);
    for (int i = 0; i < 8; i++) step(1, 1, 0, i == 0, 0);
    chk("good parity fv", frame_valid, 1);
    chk("parity_out", parity_out, 1);
    parity_in = 0;
`endif
    repeat (3) @(posedge clk);
    #1 chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1to8_collect.md
Name: demux1to8_collect

Overview:
- Sequential 1-to-N demultiplexer and frame collector; the receive-side counterpart of the team's 8:1 selector.
- Routes a narrow input stream into N registered lanes, chosen either by an explicit select or by an internal auto-increment pointer.
- Tracks which lanes have been written in the current frame.
- When every lane has been written, snapshots all lanes into a frame register and pulses frame_valid.
- Sits downstream of a serialising mux to rebuild parallel words.

Parameters:
- DATA_W, 1, width of each lane and of din.
- N_CH, 8, number of output lanes (2..16).
- SEL_W, 3, width of sel and ptr; must equal $clog2(N_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_W  input data.
- din_valid  input  1  write strobe; din is accepted on each rising edge where it is high.
- sel  input  SEL_W  target lane in manual mode.
- auto_en  input  1  1 = target is ptr, 0 = target is sel.
- clear  input  1  synchronous frame abort.
- lane_out  output  N_CH*DATA_W  live lane registers; lane k is bits [k*DATA_W +: DATA_W].
- frame_out  output  N_CH*DATA_W  snapshot of the last completed frame.
- frame_valid  output  1  one-cycle pulse when frame_out updates.
- wr_mask  output  N_CH  lanes written in the current frame.
- ptr  output  SEL_W  auto-mode write pointer.
- busy  output  1  high while a frame is partially filled.

Behaviour:
- Reset (rst=1 at a clock edge): lane_out=0, frame_out=0, frame_valid=0, wr_mask=0, ptr=0, busy=0, state=IDLE. Reset overrides every other input.
- Priority, highest first: rst, clear, din_valid.
- Target lane t is ptr when auto_en=1, otherwise sel. If t >= N_CH, the write is dropped: no state changes and ptr does not advance.
- Accepted write at edge k:
  - lane_out[t] = din, visible after edge k (1-cycle latency).
  - wr_mask |= onehot(t).
  - In auto mode, ptr advances by 1 and wraps from N_CH-1 to 0. In manual mode ptr is unchanged.
- Rewriting an already-written lane in the same frame overwrites its data; wr_mask is unchanged.
- Completion: a write for which (wr_mask | onehot(t)) is all-ones. At that same edge:
  - frame_out takes the full lane set including the new din.
  - frame_valid=1 for exactly one cycle.
  - wr_mask=0 and ptr=0.
  - lane_out keeps its values.
- State machine:
  - IDLE: wr_mask==0. A non-completing write goes to FILL; a completing write (N_CH==1 only) goes to DONE.
  - FILL: completing write goes to DONE; other writes stay in FILL.
  - DONE: lasts one cycle (frame_valid=1). A write in this cycle starts the next frame and goes to FILL; otherwise go to IDLE.
  - Any state: clear goes to IDLE.
- busy = (state==FILL).
- clear: wr_mask=0, ptr=0, lane_out=0, frame_valid=0. frame_out is held. A din_valid in the same cycle is ignored.
- Toggling auto_en mid-frame is legal. ptr is not resynchronised to sel, and wr_mask continues accumulating.
- Back-to-back frames at full rate are supported: one frame_valid every N_CH cycles, with no bubble.

Optional Feature:
- Macro DEMUX_COLLECT_PARITY_EN.
- When defined:
  - Adds an extra output port parity_out (1 bit) and an extra input port parity_in (1 bit).
  - parity_out = XOR of all bits of frame_out; it is registered and updates in the same cycle as frame_out.
  - parity_in is sampled at completion. If it differs from the computed parity, frame_valid is suppressed and frame_out is not updated.
  - parity_out resets to 0.
- When undefined: neither port exists, and every completion updates frame_out and pulses frame_valid.

Test Plan:
- Auto mode, din_valid=1 for 8 cycles with din=1,0,1,1,0,0,1,0 → frame_out=8'b01001101 and a single frame_valid pulse on the 8th edge; ptr=0 and wr_mask=0 afterwards.
- Manual mode, sel order 7,3,0,5,1,6,2,4 with din=1 each → frame_valid only after the 8th write, frame_out=8'hFF. A repeat sel=3 with din=0 before completion leaves wr_mask unchanged and changes lane 3 only.
- Auto mode, 16 continuous writes of alternating 1/0 → two frame_valid pulses 8 cycles apart, each frame_out=8'h55; busy low only in the DONE/IDLE cycles.
- After 4 writes, assert clear together with din_valid=1 → wr_mask=0, ptr=0, lane_out=0, frame_out keeps the previous 8'h55, no frame_valid; the next 8 writes complete normally.
- Assert rst mid-frame (wr_mask=8'h0F) → all outputs 0 on the next cycle. With DEMUX_COLLECT_PARITY_EN defined, a frame of 8'h01 with parity_in=0 produces no frame_valid and leaves frame_out unchanged; with parity_in=1 it is accepted and parity_out=1.
